game_controller: RTL and testbench
==================================

# game_controller

Frame-rate game sequencer that drives the ball-rendering pixel stage. It owns the game state machine (idle / playing / lost), moves the allied ball from four direction buttons, and bounces the enemy ball off the screen edges. Once per frame it checks for a collision between the two circles. Its outputs (ativo, perdeu, ball centres and radii) feed the renderer directly; the frame tick is derived from the renderer's VGA_X/VGA_Y scan coordinates.

## Interface
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in lines
- ALLY_R, 10, allied radius (px)
- ENEMY_R, 16, enemy radius (px)
- ALLY_STEP, 4, allied move per frame per axis (px)
- ENEMY_STEP, 2, enemy move per frame per axis (px)
- ALLY_X0 / ALLY_Y0, 320 / 240, allied start centre
- ENEMY_X0 / ENEMY_Y0, 100 / 100, enemy start centre; enemy start direction is +x, +y

- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  level button, synchronous; a rising edge starts or restarts the game
- btn_left, btn_right, btn_up, btn_down  in  1 each  level, synchronous
- VGA_X, VGA_Y  in  10 each  current scan coordinates
- ativo  out  1  game running or showing the lost state
- perdeu  out  1  collision occurred
- x_bola_aliada, y_bola_aliada, raio_bola_aliada  out  10 each
- x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga  out  10 each
- score  out  16  frames survived, saturating

## Operation
- States: IDLE, PLAYING, MOVE, COLLIDE, LOST.
- Reset values:
  - State is IDLE; ativo and perdeu are 0; score is 0.
  - Centres are at the start parameters; enemy direction is +x, +y.
  - Radius outputs always equal ALLY_R / ENEMY_R.
- Start edge: a registered rising edge of start. In IDLE or LOST it reloads the start centres and direction, clears score and perdeu, and goes to PLAYING. In any other state it is ignored.
- Frame tick: a one-cycle pulse on the first cycle where VGA_Y == V_RES while the registered previous VGA_Y == V_RES-1. The tick acts only in PLAYING; it is ignored in every other state.
- PLAYING -> MOVE on a tick.
- MOVE (one cycle) updates the centres at the end of the cycle.
  - Allied x: left alone subtracts ALLY_STEP, clamped to ≥ ALLY_R. Right alone adds ALLY_STEP, clamped to ≤ H_RES-1-ALLY_R. Left and right together, or neither, means no change. y works the same with up/down against V_RES.
  - Enemy, per axis: next = pos ± ENEMY_STEP. If next crosses [ENEMY_R, bound-1-ENEMY_R], the centre is clamped to the boundary and that axis direction flips in the same cycle.
- COLLIDE (one cycle) evaluates the updated centres.
  - dx = |xa-xe| (10b), dy = |ya-ye| (10b).
  - d² = dx²+dy² (21b unsigned); rs² = (ALLY_R+ENEMY_R)² (22b).
  - Hit when d² ≤ rs², so touching counts as a hit.
  - Hit: go to LOST with perdeu=1; score is unchanged.
  - No hit: score+1, saturating at 0xFFFF; go to PLAYING.
- LOST: ativo=1, perdeu=1, centres frozen until a start edge.
- ativo = 1 in PLAYING, MOVE, COLLIDE and LOST; 0 in IDLE.

## Timing
- Tick detected at cycle t. MOVE is at t+1; new centres are visible at t+2. COLLIDE is at t+2; perdeu/score update is visible at t+3.
- Start edge: the button rises at cycle s, the edge is registered at s+1, and ativo=1 with reloaded centres is visible at s+2.
- All outputs are registered; no output is combinational from an input.
- Reset asserted mid-frame or in MOVE/COLLIDE returns immediately to the reset values. Pending edges and ticks are discarded.
- Buttons are sampled only in MOVE. Button changes between ticks have no effect.

## Structure
- Shared package game_pkg: state enum encoding, H_RES/V_RES defaults, coordinate width (10).
- Sub-module circle_collide: registered compare of two centres plus a radius sum, producing a hit flag. It is reusable for future objects.
- Tick and edge detectors are inline.

## Test plan
- Reset, then start edge → ativo=1 two cycles later; ally (320,240), enemy (100,100); score=0, perdeu=0.
- Hold btn_right for 3 ticks → x_bola_aliada 320→332, y unchanged; score=3. Hold left+right together → x unchanged.
- Place the ally near the right wall (x=628) and tick with right held → x clamps at 629 (H_RES-1-ALLY_R), not 632.
- Enemy at x=622 moving +x, one tick → x=623 (639-16) and direction flips; the next tick gives x=621.
- Force centres 26 px apart horizontally (radius sum = 26) → perdeu=1, state LOST, centres frozen over further ticks. A start edge then restores the start positions with score=0.
- Assert reset during MOVE → all outputs at reset values the same cycle; the first tick after a later start moves by exactly one step.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types, defaults and per-axis motion helpers for the game sequencer.
package game_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned SCORE_W   = 16;
  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } ball_t;

  // dir = 1 means moving toward larger coordinates
  typedef struct packed {
    logic   dir;
    coord_t pos;
  } axis_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAYING = 3'd1,
    ST_MOVE    = 3'd2,
    ST_COLLIDE = 3'd3,
    ST_LOST    = 3'd4
  } state_e;

  // Button-driven axis: opposing buttons cancel, result clamped to [lo, hi].
  function automatic coord_t ally_axis(input coord_t pos, input logic dec, input logic inc,
                                       input coord_t step, input coord_t lo, input coord_t hi);
    coord_t nxt;
    nxt = pos;
    if (dec && !inc) begin
      nxt = (pos < lo + step) ? lo : pos - step;
    end else if (inc && !dec) begin
      nxt = (pos > hi - step) ? hi : pos + step;
    end
    return nxt;
  endfunction

  // Bouncing axis: overshoot clamps to the wall and reverses in the same step.
  function automatic axis_t enemy_axis(input axis_t cur, input coord_t step,
                                       input coord_t lo, input coord_t hi);
    axis_t nxt;
    nxt = cur;
    if (cur.dir) begin
      if (cur.pos > hi - step) begin
        nxt.pos = hi;
        nxt.dir = 1'b0;
      end else begin
        nxt.pos = cur.pos + step;
      end
    end else begin
      if (cur.pos < lo + step) begin
        nxt.pos = lo;
        nxt.dir = 1'b1;
      end else begin
        nxt.pos = cur.pos - step;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Controller <-> renderer/button bus; master is the game controller side.
interface game_controller_if;
  import game_pkg::*;

  logic               start;
  logic               btn_left;
  logic               btn_right;
  logic               btn_up;
  logic               btn_down;
  coord_t             VGA_X;
  coord_t             VGA_Y;
  logic               ativo;
  logic               perdeu;
  coord_t             x_bola_aliada;
  coord_t             y_bola_aliada;
  coord_t             raio_bola_aliada;
  coord_t             x_bola_inimiga;
  coord_t             y_bola_inimiga;
  coord_t             raio_bola_inimiga;
  logic [SCORE_W-1:0] score;

  modport master (
    input  start, btn_left, btn_right, btn_up, btn_down, VGA_X, VGA_Y,
    output ativo, perdeu, x_bola_aliada, y_bola_aliada, raio_bola_aliada,
           x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga, score
  );

  modport slave (
    output start, btn_left, btn_right, btn_up, btn_down, VGA_X, VGA_Y,
    input  ativo, perdeu, x_bola_aliada, y_bola_aliada, raio_bola_aliada,
           x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga, score
  );
endinterface

// File: rtl/circle_collide.sv
// Registered circle-overlap test: hit when the centre distance squared is
// within the squared radius sum (touching counts).
module circle_collide
  import game_pkg::*;
#(
  parameter int unsigned CW = COORD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  ball_t         a,
  input  ball_t         b,
  input  logic [CW:0]   r_sum,
  output logic          hit_q
);

  localparam int unsigned D2_W  = 2 * CW + 1;
  localparam int unsigned RS2_W = 2 * (CW + 1);

  coord_t             dx_c;
  coord_t             dy_c;
  logic [D2_W-1:0]    dxe_c;
  logic [D2_W-1:0]    dye_c;
  logic [D2_W-1:0]    d2_c;
  logic [RS2_W-1:0]   rs_c;
  logic [RS2_W-1:0]   rs2_c;
  logic               hit_d;

  always_comb begin
    dx_c  = (a.x >= b.x) ? a.x - b.x : b.x - a.x;
    dy_c  = (a.y >= b.y) ? a.y - b.y : b.y - a.y;
    dxe_c = D2_W'(dx_c);
    dye_c = D2_W'(dy_c);
    d2_c  = dxe_c * dxe_c + dye_c * dye_c;
    rs_c  = RS2_W'(r_sum);
    rs2_c = rs_c * rs_c;
    hit_d = (RS2_W'(d2_c) <= rs2_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_q <= 1'b0;
    else       hit_q <= hit_d;
  end

endmodule

// File: rtl/game_controller.sv
// Frame-rate game sequencer: start/tick detection, ball motion, collision
// bookkeeping and registered outputs for the ball renderer.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned H_RES      = H_RES_DEF,
  parameter int unsigned V_RES      = V_RES_DEF,
  parameter int unsigned ALLY_R     = 10,
  parameter int unsigned ENEMY_R    = 16,
  parameter int unsigned ALLY_STEP  = 4,
  parameter int unsigned ENEMY_STEP = 2,
  parameter int unsigned ALLY_X0    = 320,
  parameter int unsigned ALLY_Y0    = 240,
  parameter int unsigned ENEMY_X0   = 100,
  parameter int unsigned ENEMY_Y0   = 100
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  game_controller_if.master bus
);

  localparam coord_t A_LO    = COORD_W'(ALLY_R);
  localparam coord_t A_HI_X  = COORD_W'(H_RES - 1 - ALLY_R);
  localparam coord_t A_HI_Y  = COORD_W'(V_RES - 1 - ALLY_R);
  localparam coord_t E_LO    = COORD_W'(ENEMY_R);
  localparam coord_t E_HI_X  = COORD_W'(H_RES - 1 - ENEMY_R);
  localparam coord_t E_HI_Y  = COORD_W'(V_RES - 1 - ENEMY_R);
  localparam coord_t A_STEP  = COORD_W'(ALLY_STEP);
  localparam coord_t E_STEP  = COORD_W'(ENEMY_STEP);
  localparam coord_t Y_LAST  = COORD_W'(V_RES - 1);
  localparam coord_t Y_TICK  = COORD_W'(V_RES);
  localparam ball_t  ALLY_START = '{x: COORD_W'(ALLY_X0), y: COORD_W'(ALLY_Y0)};
  localparam axis_t  EX_START   = '{dir: 1'b1, pos: COORD_W'(ENEMY_X0)};
  localparam axis_t  EY_START   = '{dir: 1'b1, pos: COORD_W'(ENEMY_Y0)};
  localparam logic [COORD_W:0] R_SUM = (COORD_W + 1)'(ALLY_R + ENEMY_R);

  state_e             state_q, state_d;
  ball_t              ally_q, ally_d;
  axis_t              ex_q, ex_d, ey_q, ey_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               ativo_q, ativo_d;
  logic               perdeu_q, perdeu_d;
  logic               start_q, start_d;
  logic               start_prev_q, start_prev_d;
  coord_t             vga_y_prev_q, vga_y_prev_d;

  logic               start_edge;
  logic               frame_tick;
  logic               hit_q;
  ball_t              enemy_ball_d;
  logic               unused_vga_x;

  assign start_edge   = start_q & ~start_prev_q;
  assign frame_tick   = (bus.VGA_Y == Y_TICK) && (vga_y_prev_q == Y_LAST);
  assign enemy_ball_d = '{x: ex_d.pos, y: ey_d.pos};
  assign unused_vga_x = ^bus.VGA_X;

  // Fed with next-cycle centres so the hit flag is ready during COLLIDE.
  circle_collide #(.CW(COORD_W)) u_collide (
    .clk   (CLOCK_50),
    .reset (reset),
    .a     (ally_d),
    .b     (enemy_ball_d),
    .r_sum (R_SUM),
    .hit_q (hit_q)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ally_q       <= ALLY_START;
      ex_q         <= EX_START;
      ey_q         <= EY_START;
      score_q      <= '0;
      ativo_q      <= 1'b0;
      perdeu_q     <= 1'b0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      vga_y_prev_q <= '0;
    end else begin
      state_q      <= state_d;
      ally_q       <= ally_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      score_q      <= score_d;
      ativo_q      <= ativo_d;
      perdeu_q     <= perdeu_d;
      start_q      <= start_d;
      start_prev_q <= start_prev_d;
      vga_y_prev_q <= vga_y_prev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ally_d       = ally_q;
    ex_d         = ex_q;
    ey_d         = ey_q;
    score_d      = score_q;
    perdeu_d     = perdeu_q;
    start_d      = bus.start;
    start_prev_d = start_q;
    vga_y_prev_d = bus.VGA_Y;

    unique case (state_q)
      ST_IDLE, ST_LOST: begin
        if (start_edge) begin
          ally_d   = ALLY_START;
          ex_d     = EX_START;
          ey_d     = EY_START;
          score_d  = '0;
          perdeu_d = 1'b0;
          state_d  = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (frame_tick) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        ally_d.x = ally_axis(ally_q.x, bus.btn_left, bus.btn_right, A_STEP, A_LO, A_HI_X);
        ally_d.y = ally_axis(ally_q.y, bus.btn_up, bus.btn_down, A_STEP, A_LO, A_HI_Y);
        ex_d     = enemy_axis(ex_q, E_STEP, E_LO, E_HI_X);
        ey_d     = enemy_axis(ey_q, E_STEP, E_LO, E_HI_Y);
        state_d  = ST_COLLIDE;
      end
      ST_COLLIDE: begin
        if (hit_q) begin
          perdeu_d = 1'b1;
          state_d  = ST_LOST;
        end else begin
          score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
          state_d = ST_PLAYING;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ativo_d = (state_d != ST_IDLE);
  end

  assign bus.ativo             = ativo_q;
  assign bus.perdeu            = perdeu_q;
  assign bus.score             = score_q;
  assign bus.x_bola_aliada     = ally_q.x;
  assign bus.y_bola_aliada     = ally_q.y;
  assign bus.raio_bola_aliada  = A_LO;
  assign bus.x_bola_inimiga    = ex_q.pos;
  assign bus.y_bola_inimiga    = ey_q.pos;
  assign bus.raio_bola_inimiga = E_LO;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: start, movement, clamping, bounce,
// exact-touch collision and reset during MOVE.
module tb_game_controller;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  game_controller_if bus ();

  game_controller dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_ally(input string tag, input int x, input int y);
    check({tag, "_ax"}, 32'(bus.x_bola_aliada), 32'(x));
    check({tag, "_ay"}, 32'(bus.y_bola_aliada), 32'(y));
  endtask

  task automatic check_enemy(input string tag, input int x, input int y);
    check({tag, "_ex"}, 32'(bus.x_bola_inimiga), 32'(x));
    check({tag, "_ey"}, 32'(bus.y_bola_inimiga), 32'(y));
  endtask

  task automatic check_status(input string tag, input int ativo, input int perdeu, input int score);
    check({tag, "_ativo"},  32'(bus.ativo),  32'(ativo));
    check({tag, "_perdeu"}, 32'(bus.perdeu), 32'(perdeu));
    check({tag, "_score"},  32'(bus.score),  32'(score));
  endtask

  // One frame boundary: 479 -> 480, then wait through MOVE and COLLIDE.
  task automatic do_tick();
    @(negedge clk) bus.VGA_Y = 10'd479;
    @(negedge clk) bus.VGA_Y = 10'd480;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic press_start();
    @(negedge clk) bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_btns(input logic l, input logic r, input logic u, input logic d);
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.btn_up    = u;
    bus.btn_down  = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.start = 1'b0;
    set_btns(1'b0, 1'b0, 1'b0, 1'b0);
    bus.VGA_X = '0;
    bus.VGA_Y = '0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_status("rst", 0, 0, 0);
    check_ally("rst", 320, 240);
    check_enemy("rst", 100, 100);
    check("rst_ra", 32'(bus.raio_bola_aliada), 32'd10);
    check("rst_re", 32'(bus.raio_bola_inimiga), 32'd16);

    // Start edge: ativo one cycle after registration, not before
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) check("start_s1_ativo", 32'(bus.ativo), 32'd0);
    @(negedge clk) check("start_s2_ativo", 32'(bus.ativo), 32'd1);
    bus.start = 1'b0;
    check_status("start", 1, 0, 0);
    check_ally("start", 320, 240);
    check_enemy("start", 100, 100);

    // First tick with right held, cycle-exact
    set_btns(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk) bus.VGA_Y = 10'd479;
    @(negedge clk) bus.VGA_Y = 10'd480;
    @(negedge clk) check("t1_move_x_old", 32'(bus.x_bola_aliada), 32'd320);
    @(negedge clk) check("t1_x_new", 32'(bus.x_bola_aliada), 32'd324);
    check("t1_score_old", 32'(bus.score), 32'd0);
    @(negedge clk) check("t1_score_new", 32'(bus.score), 32'd1);
    check_enemy("t1", 102, 102);

    do_ticks(2);
    check_ally("right3", 332, 240);
    check("right3_score", 32'(bus.score), 32'd3);

    // Left and right together cancel
    set_btns(1'b1, 1'b1, 1'b0, 1'b0);
    do_ticks(2);
    check_ally("both", 332, 240);
    check("both_score", 32'(bus.score), 32'd5);

    // Walk to the right wall and clamp
    set_btns(1'b0, 1'b1, 1'b0, 1'b0);
    do_ticks(74);
    check_ally("near_wall", 628, 240);
    do_tick();
    check_ally("wall_clamp", 629, 240);
    check_enemy("n80", 260, 260);
    check_status("n80", 1, 0, 80);

    // Enemy to x=622, then bounce on the right wall
    set_btns(1'b0, 1'b0, 1'b0, 1'b0);
    do_ticks(181);
    check_enemy("n261", 622, 305);
    do_tick();
    check_enemy("bounce", 623, 303);
    do_tick();
    check_enemy("after_bounce", 621, 301);
    check_status("n263", 1, 0, 263);
    check_ally("n263", 629, 240);

    // Reset asserted while in MOVE
    set_btns(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk) bus.VGA_Y = 10'd479;
    @(negedge clk) bus.VGA_Y = 10'd480;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_status("rst_move", 0, 0, 0);
    check_ally("rst_move", 320, 240);
    check_enemy("rst_move", 100, 100);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_idle", 32'(bus.ativo), 32'd0);

    // Restart; first tick moves exactly one step
    press_start();
    check_status("restart", 1, 0, 0);
    do_tick();
    check_ally("restart_t1", 324, 240);
    check_enemy("restart_t1", 102, 102);
    check("restart_t1_score", 32'(bus.score), 32'd1);

    // Steer the ally to (492,469), bottom wall clamp included
    set_btns(1'b0, 1'b1, 1'b0, 1'b1);
    do_ticks(42);
    check_ally("diag", 492, 408);
    set_btns(1'b0, 1'b0, 1'b0, 1'b1);
    do_ticks(16);
    check_ally("bottom_clamp", 492, 469);
    set_btns(1'b0, 1'b0, 1'b0, 1'b0);

    // Near miss (d^2 = 740), then exact touch (d^2 = 676)
    do_ticks(124);
    check_enemy("near_miss", 466, 461);
    check_status("near_miss", 1, 0, 183);
    do_tick();
    check_enemy("touch", 468, 459);
    check_status("touch", 1, 1, 183);

    // LOST freezes everything
    set_btns(1'b1, 1'b0, 1'b1, 1'b0);
    do_ticks(3);
    check_ally("lost_frozen", 492, 469);
    check_enemy("lost_frozen", 468, 459);
    check_status("lost_frozen", 1, 1, 183);
    set_btns(1'b0, 1'b0, 1'b0, 1'b0);

    // Start edge from LOST restores the start positions
    press_start();
    check_status("relaunch", 1, 0, 0);
    check_ally("relaunch", 320, 240);
    check_enemy("relaunch", 100, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
